// File: rtl/comp_seq.sv
// Multi-cycle magnitude comparator, MSB-first, CHUNK bits per RUN cycle, unsigned or two's-complement.
// Latency: NCHUNK cycles from accepted start to done (1..NCHUNK with COMP_EARLY_EXIT_EN defined).
// Backpressure: start is ignored while busy; one compare per NCHUNK+1 cycles when start is held.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request, sampled only when idle
//   A, B              WIDTH-bit operands, latched on accepted start
//   signed_mode       1 = two's-complement compare, latched on accepted start
//   busy              compare in progress
//   done              one-cycle pulse when gt/eq/lt update
//   gt, eq, lt        registered result flags, held until the next completion
//
// Optional feature macro: COMP_EARLY_EXIT_EN (finish on the first differing chunk).
module comp_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef COMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             dgt_q, dgt_d;     // recorded direction once decided (1 = A greater)
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [CHUNK-1:0] top_a, top_b;
  logic             differ, new_dec, fin_gt, fin_lt, complete;

  assign top_a = sa_q[WIDTH-1 -: CHUNK];
  assign top_b = sb_q[WIDTH-1 -: CHUNK];
  assign differ  = (top_a != top_b);
  assign new_dec = differ && !decided_q;

  // Final direction: an earlier recorded decision always wins over this chunk.
  assign fin_gt = decided_q ? dgt_q  : (differ && (top_a > top_b));
  assign fin_lt = decided_q ? !dgt_q : (differ && (top_a < top_b));

  assign complete = (cnt_q == LAST) || (EARLY_EXIT && new_dec);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      dgt_q     <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      dgt_q     <= dgt_d;
      done_q    <= done_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    dgt_d     = dgt_q;
    done_d    = 1'b0;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Flipping both MSBs maps two's-complement order onto unsigned order.
          sa_d      = signed_mode ? (A ^ MSB_MASK) : A;
          sb_d      = signed_mode ? (B ^ MSB_MASK) : B;
          cnt_d     = '0;
          decided_d = 1'b0;
          dgt_d     = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        sa_d = sa_q << CHUNK;
        sb_d = sb_q << CHUNK;
        if (new_dec) begin
          decided_d = 1'b1;
          dgt_d     = (top_a > top_b);
        end
        if (complete) begin
          gt_d    = fin_gt;
          lt_d    = fin_lt;
          eq_d    = !(fin_gt || fin_lt);
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_comp_seq.sv
// Self-checking bench for comp_seq: directed cases plus randomized compares against an arithmetic model.
// Latency: expected done timing derived from first differing chunk when COMP_EARLY_EXIT_EN is defined.
// Backpressure: exercises start-while-busy rejection and continuously held start.
module tb_comp_seq;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        signed_mode = 1'b0;
  logic        busy, done, gt, eq, lt;

  int checks = 0;
  int errors = 0;

  // Model of the held result flags.
  int m_gt = 0, m_eq = 0, m_lt = 0;

  comp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .signed_mode(signed_mode), .busy(busy), .done(done),
    .gt(gt), .eq(eq), .lt(lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_order(input logic [15:0] a, input logic [15:0] b, input logic m);
    // +1: A > B, 0: equal, -1: A < B
    if (m) return ($signed(a) > $signed(b)) ? 1 : (($signed(a) < $signed(b)) ? -1 : 0);
    return (a > b) ? 1 : ((a < b) ? -1 : 0);
  endfunction

  function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef COMP_EARLY_EXIT_EN
    for (int i = 0; i < NCHUNK; i++) begin
      logic [15:0] ca, cb;
      ca = (a >> (WIDTH - CHUNK * (i + 1))) & 16'h000F;
      cb = (b >> (WIDTH - CHUNK * (i + 1))) & 16'h000F;
      if (ca != cb) return i + 1;
    end
`else
    if (a == b) return NCHUNK;  // keeps both arguments meaningful in this build
`endif
    return NCHUNK;
  endfunction

  task automatic check_flags(input string tag);
    chk({tag, ".gt"}, int'(gt), m_gt);
    chk({tag, ".eq"}, int'(eq), m_eq);
    chk({tag, ".lt"}, int'(lt), m_lt);
  endtask

  task automatic run_cmp(input string tag, input logic [15:0] a, input logic [15:0] b, input logic m);
    int o, lat, n;
    bit seen;
    o   = exp_order(a, b, m);
    lat = exp_lat(a, b);
    @(negedge clk);
    A = a; B = b; signed_mode = m; start = 1'b1;
    edge_step();
    start = 1'b0;
    chk({tag, ".busy_acc"}, int'(busy), 1);
    chk({tag, ".done_acc"}, int'(done), 0);
    check_flags({tag, ".held"});
    n = 0; seen = 1'b0;
    while (!seen && n < 2 * NCHUNK + 2) begin
      edge_step();
      n++;
      if (done) seen = 1'b1;
    end
    chk({tag, ".done_seen"}, int'(seen), 1);
    chk({tag, ".latency"}, n, lat);
    m_gt = (o > 0) ? 1 : 0;
    m_eq = (o == 0) ? 1 : 0;
    m_lt = (o < 0) ? 1 : 0;
    check_flags(tag);
    chk({tag, ".busy_end"}, int'(busy), 0);
    edge_step();
    chk({tag, ".done_pulse"}, int'(done), 0);
    check_flags({tag, ".hold"});
  endtask

  initial begin
    int dones, last_done, cyc;
    logic [15:0] ra, rb;
    logic        rm;

    // Reset state
    edge_step(); edge_step();
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    check_flags("rst");
    @(negedge clk); rst = 1'b0;

    // Directed cases
    run_cmp("eq1234",   16'h1234, 16'h1234, 1'b0);
    run_cmp("u8000",    16'h8000, 16'h7FFF, 1'b0);
    run_cmp("s8000",    16'h8000, 16'h7FFF, 1'b1);
    run_cmp("sFFFF",    16'hFFFF, 16'h0001, 1'b1);
    run_cmp("early",    16'h5000, 16'h4FFF, 1'b0);
    run_cmp("lastchk",  16'h1230, 16'h1231, 1'b0);

    // Start while busy must be ignored
    @(negedge clk);
    A = 16'h0001; B = 16'h0002; signed_mode = 1'b0; start = 1'b1;
    edge_step();                     // edge 0
    start = 1'b0;
    edge_step();                     // edge 1
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0000; start = 1'b1;
    edge_step();                     // edge 2
    start = 1'b0;
    chk("busyrej.busy", int'(busy), 1);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      edge_step();
      if (done) dones++;
    end
    chk("busyrej.dones", dones, 1);
    m_gt = 0; m_eq = 0; m_lt = 1;
    check_flags("busyrej");

    // Reset in the middle of a compare
    @(negedge clk);
    A = 16'h00F0; B = 16'h000F; start = 1'b1;
    edge_step();                     // edge 0
    start = 1'b0;
    edge_step();                     // edge 1
    @(negedge clk); rst = 1'b1;
    edge_step();                     // edge 2
    m_gt = 0; m_eq = 0; m_lt = 0;
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    check_flags("midrst");
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      edge_step();
      if (done) dones++;
    end
    chk("midrst.nodone", dones, 0);
    run_cmp("postrst", 16'h0000, 16'h0000, 1'b0);

    // Held start: one compare every NCHUNK+1 cycles
    @(negedge clk);
    A = 16'h1234; B = 16'h1234; signed_mode = 1'b0; start = 1'b1;
    dones = 0; last_done = -1;
    for (cyc = 0; cyc < 22; cyc++) begin
      edge_step();
      if (done) begin
        if (last_done >= 0) chk("b2b.interval", cyc - last_done, NCHUNK + 1);
        last_done = cyc;
        dones++;
      end
    end
    chk("b2b.count", dones, 4);
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (busy && cyc < 2 * NCHUNK) begin
      edge_step();
      cyc++;
    end
    chk("b2b.drain", int'(busy), 0);
    edge_step();
    m_gt = 0; m_eq = 1; m_lt = 0;
    check_flags("b2b");

    // Randomized compares
    for (int t = 0; t < 40; t++) begin
      ra = 16'($urandom);
      rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (16'h000F << (4 * $urandom_range(0, 3)));
        2:       rb = ra ^ 16'h8000;
        default: rb = 16'($urandom);
      endcase
      run_cmp($sformatf("rnd%0d", t), ra, rb, rm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 expected=1");
    $fatal(1, "timeout");
  end

endmodule
